// File: rtl/mem_if_arbiter.sv
// mem_if_arbiter: shares one burst memory port between NUM_CH line caches
// (channel 0 = I-cache). A request wins arbitration in IDLE, the line is moved
// as BURST_LEN beats in BUSY, and a one-cycle DONE state reports completion.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   reqValid/reqWrite   per-channel line request and direction (1 = write)
//   reqAdr/reqWdata     per-channel byte address and current write word
//   reqReady            one-cycle grant pulse to the winning channel
//   wdataNext           write beat consumed this cycle, present the next word
//   rdValid/rdData      read beat strobe (per channel) and shared read data
//   done                one-cycle transfer-complete pulse
//   memReq/memWrite     memory transfer active and its direction
//   memAdr/memWdata     current beat address and write data
//   memAck/memRdata     beat accepted/delivered by memory and its read data
module mem_if_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int WORD_LENGTH = 32,
  parameter int ADR_WIDTH   = 32,
  parameter int BURST_LEN   = 4,
  parameter int RR_MODE     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             reqValid,
  input  logic [NUM_CH-1:0]             reqWrite,
  input  logic [NUM_CH*ADR_WIDTH-1:0]   reqAdr,
  input  logic [NUM_CH*WORD_LENGTH-1:0] reqWdata,
  output logic [NUM_CH-1:0]             reqReady,
  output logic [NUM_CH-1:0]             wdataNext,
  output logic [NUM_CH-1:0]             rdValid,
  output logic [WORD_LENGTH-1:0]        rdData,
  output logic [NUM_CH-1:0]             done,
  output logic                          memReq,
  output logic                          memWrite,
  output logic [ADR_WIDTH-1:0]          memAdr,
  output logic [WORD_LENGTH-1:0]        memWdata,
  input  logic                          memAck,
  input  logic [WORD_LENGTH-1:0]        memRdata
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LINE_BITS = $clog2(BURST_LEN * WORD_LENGTH / 8);
  localparam int unsigned NCH = NUM_CH;

  localparam logic [ADR_WIDTH-1:0] BYTES     = ADR_WIDTH'(WORD_LENGTH / 8);
  localparam logic [ADR_WIDTH-1:0] LINE_MASK =
    ~((ADR_WIDTH'(1) << LINE_BITS) - ADR_WIDTH'(1));
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [CH_W-1:0]      ch;
  logic [CH_W-1:0]      rr_ptr;
  logic                 dir;
  logic [ADR_WIDTH-1:0] base;
  logic [BEAT_W-1:0]    beat;

  logic [CH_W-1:0]      win;
  logic                 found;
  int unsigned          idx;

  // Arbitration: scan channels in priority order. In round-robin mode the
  // scan starts just above the last granted channel and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (RR_MODE != 0) begin
        idx = int'(rr_ptr) + k + 1;
        if (idx >= NCH) idx = idx - NCH;
      end else begin
        idx = k;
      end
      if (!found && reqValid[CH_W'(idx)]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  // The memory-side signals and wdataNext must follow memAck/reqWdata in the
  // same cycle, so they are decoded from the registered state.
  assign memReq   = (state == BUSY);
  assign memWrite = memReq & dir;
  assign memAdr   = memReq ? (base + (ADR_WIDTH'(beat) * BYTES)) : '0;
  assign memWdata = memReq ? reqWdata[ch*WORD_LENGTH +: WORD_LENGTH] : '0;

  always_comb begin
    wdataNext = '0;
    if (memReq && dir && memAck) wdataNext[ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ch       <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
      dir      <= 1'b0;
      base     <= '0;
      beat     <= '0;
      reqReady <= '0;
      rdValid  <= '0;
      done     <= '0;
      rdData   <= '0;
    end else begin
      reqReady <= '0;
      rdValid  <= '0;
      done     <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ch            <= win;
            rr_ptr        <= win;
            dir           <= reqWrite[win];
            base          <= reqAdr[win*ADR_WIDTH +: ADR_WIDTH] & LINE_MASK;
            beat          <= '0;
            reqReady[win] <= 1'b1;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (memAck) begin
            beat <= beat + 1'b1;
            if (!dir) begin
              rdData      <= memRdata;
              rdValid[ch] <= 1'b1;
            end
            if (beat == LAST_BEAT) begin
              done[ch] <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
